// File: rtl/pa_dst_writeback.sv
// Output write-back stage: buffers packed int8 results in a small FIFO and
// writes them as consecutive words to destination memory for one job.
module pa_dst_writeback #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] dst_base_addr,
   input  logic [31:0]       lhs_rows,
   input  logic [31:0]       rhs_rows,
   input  logic [DATA_W-1:0] result_in,
   input  logic              write_rdy,
   output logic              write_acq,
   output logic              mem_wr_req,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic              mem_wr_gnt,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] base_addr;
   logic [31:0]       total_words;
   logic [31:0]       in_cnt;
   logic [31:0]       out_cnt;
   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    fifo_cnt;
   logic              err_q;
   logic              done_q;
   logic              cfg_bad;
   logic [31:0]       job_words;
   logic              push;
   logic              pop;
   logic              unused_cfg;

   assign unused_cfg = ^{lhs_rows[31:16], rhs_rows[31:18]};
   assign cfg_bad    = (rhs_rows[1:0] != 2'b00);
   assign job_words  = 32'(lhs_rows[15:0]) * 32'(rhs_rows[17:2]);
   assign push       = write_rdy && write_acq;
   assign pop        = mem_wr_req && mem_wr_gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A zero-sized job still passes through FIN so the caller sees done.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start && !cfg_bad) begin
               state_next = (job_words == 32'd0) ? FIN : RUN;
            end
         end
         RUN: begin
            if (out_cnt == total_words) begin
               state_next = FIN;
            end
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Address and data are forced to zero whenever no request is pending.
   always_comb begin
      write_acq   = 1'b0;
      mem_wr_req  = 1'b0;
      mem_wr_addr = '0;
      mem_wr_data = '0;
      busy        = (state == RUN);
      done        = done_q;
      err         = err_q;
      if (state == RUN) begin
         write_acq  = (in_cnt < total_words) && (fifo_cnt < DEPTH_CNT);
         mem_wr_req = (fifo_cnt != '0);
      end
      if (mem_wr_req) begin
         mem_wr_addr = base_addr + ADDR_W'({out_cnt, 2'b00});
         mem_wr_data = fifo_mem[rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= result_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base_addr   <= '0;
         total_words <= '0;
         in_cnt      <= '0;
         out_cnt     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_cnt    <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= (state == FIN);
         if (state == IDLE && start) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            if (cfg_bad) begin
               err_q <= 1'b1;
            end else begin
               err_q       <= 1'b0;
               base_addr   <= dst_base_addr;
               total_words <= job_words;
            end
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            in_cnt <= in_cnt + 32'd1;
         end
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            out_cnt <= out_cnt + 32'd1;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_pa_dst_writeback.sv
// Bench for pa_dst_writeback: directed steps plus random jobs, checked
// against a queue-based scoreboard of accepted words and expected addresses.
module tb_pa_dst_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] dst_base_addr;
   logic [31:0] lhs_rows;
   logic [31:0] rhs_rows;
   logic [31:0] result_in;
   logic        write_rdy;
   logic        write_acq;
   logic        mem_wr_req;
   logic [31:0] mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic        mem_wr_gnt;
   logic        busy;
   logic        done;
   logic        err;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] q[$];
   logic [31:0] exp_base;
   logic [31:0] exp_total;
   int          nacc;
   int          nwr;
   int          ndone;
   int          data_idx;
   int          rdy_pct;
   int          gnt_pct;
   bit          seq_mode;

   pa_dst_writeback #(.DATA_W(32), .ADDR_W(32), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .dst_base_addr(dst_base_addr),
      .lhs_rows(lhs_rows), .rhs_rows(rhs_rows), .result_in(result_in),
      .write_rdy(write_rdy), .write_acq(write_acq), .mem_wr_req(mem_wr_req),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_wr_gnt(mem_wr_gnt), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] seqWord(input int k);
      logic [7:0] b;
      b = 8'(4 * k + 1);
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   // Scoreboard: words enter in acceptance order and must leave in that order
   // to base + 4*n; a request must be pending exactly when words are held.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         checkOutput("req_vs_model", 32'(mem_wr_req), 32'(q.size() != 0));
         if (mem_wr_req && mem_wr_gnt && q.size() != 0) begin
            checkOutput("wr_addr", mem_wr_addr, exp_base + 32'(4 * nwr));
            checkOutput("wr_data", mem_wr_data, q.pop_front());
            nwr++;
         end
         if (write_rdy && write_acq) begin
            checkOutput("accept_limit", 32'(32'(nacc) < exp_total), 32'd1);
            q.push_back(result_in);
            nacc++;
         end
         if (done) ndone++;
      end
   end

   // One clock of upstream/memory behaviour; result_in is held until taken.
   task automatic stepCycle();
      bit xfer;
      @(negedge clk);
      xfer = write_rdy && write_acq;
      @(posedge clk);
      #1;
      if (xfer) data_idx++;
      if (xfer || !write_rdy) begin
         write_rdy = ($urandom_range(99) < rdy_pct);
         result_in = seq_mode ? seqWord(data_idx) : $urandom;
      end
      mem_wr_gnt = ($urandom_range(99) < gnt_pct);
   endtask

   task automatic applyStimulus(input logic [31:0] base, input logic [31:0] lhs, input logic [31:0] rhs);
      exp_base      = base;
      exp_total     = 32'(lhs[15:0]) * 32'(rhs[17:2]);
      nacc          = 0;
      nwr           = 0;
      ndone         = 0;
      data_idx      = 0;
      write_rdy     = 1'b0;
      dst_base_addr = base;
      lhs_rows      = lhs;
      rhs_rows      = rhs;
      start         = 1'b1;
      stepCycle();
      start         = 1'b0;
   endtask

   task automatic runToDone(input int budget);
      int n = 0;
      while (ndone == 0 && n < budget) begin
         stepCycle();
         n++;
      end
      checkOutput("done_within_budget", 32'(ndone != 0), 32'd1);
      repeat (3) stepCycle();
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_write_acq"}, 32'(write_acq), 32'd0);
      checkOutput({tag, "_mem_wr_req"}, 32'(mem_wr_req), 32'd0);
      checkOutput({tag, "_mem_wr_addr"}, mem_wr_addr, 32'd0);
      checkOutput({tag, "_mem_wr_data"}, mem_wr_data, 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; dst_base_addr = '0; lhs_rows = '0; rhs_rows = '0;
      result_in = '0; write_rdy = 1'b0; mem_wr_gnt = 1'b0;
      exp_base = '0; exp_total = '0; nacc = 0; nwr = 0; ndone = 0; data_idx = 0;
      rdy_pct = 100; gnt_pct = 100; seq_mode = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      rst = 1'b0;

      // Normal 4-word job
      applyStimulus(32'h1000, 32'd2, 32'd8);
      checkOutput("normal_busy", 32'(busy), 32'd1);
      runToDone(50);
      checkOutput("normal_writes", 32'(nwr), 32'd4);
      checkOutput("normal_accepts", 32'(nacc), 32'd4);
      checkOutput("normal_done_count", 32'(ndone), 32'd1);
      checkOutput("normal_busy_end", 32'(busy), 32'd0);
      checkOutput("normal_acq_end", 32'(write_acq), 32'd0);

      // Backpressure: memory never grants, FIFO fills after 4 accepts
      gnt_pct = 0;
      applyStimulus(32'h1000, 32'd2, 32'd8);
      repeat (10) stepCycle();
      checkOutput("bp_accepts", 32'(nacc), 32'd4);
      checkOutput("bp_acq", 32'(write_acq), 32'd0);
      checkOutput("bp_req", 32'(mem_wr_req), 32'd1);
      checkOutput("bp_addr", mem_wr_addr, 32'h1000);
      checkOutput("bp_data", mem_wr_data, 32'h04030201);
      gnt_pct = 100;
      runToDone(50);
      checkOutput("bp_writes", 32'(nwr), 32'd4);
      checkOutput("bp_done_count", 32'(ndone), 32'd1);

      // Zero rows: done two cycles after start, no traffic
      applyStimulus(32'h1000, 32'd0, 32'd16);
      checkOutput("zero_done_c1", 32'(done), 32'd0);
      stepCycle();
      checkOutput("zero_done_c2", 32'(done), 32'd1);
      stepCycle();
      checkOutput("zero_done_c3", 32'(done), 32'd0);
      repeat (2) stepCycle();
      checkOutput("zero_writes", 32'(nwr), 32'd0);
      checkOutput("zero_err", 32'(err), 32'd0);
      checkOutput("zero_done_count", 32'(ndone), 32'd1);

      // Bad config, then a valid start clears err
      applyStimulus(32'h3000, 32'd1, 32'd6);
      checkOutput("bad_err", 32'(err), 32'd1);
      repeat (4) stepCycle();
      checkOutput("bad_err_sticky", 32'(err), 32'd1);
      checkOutput("bad_busy", 32'(busy), 32'd0);
      checkOutput("bad_acq", 32'(write_acq), 32'd0);
      checkOutput("bad_done_count", 32'(ndone), 32'd0);
      applyStimulus(32'h3000, 32'd1, 32'd4);
      checkOutput("bad_err_cleared", 32'(err), 32'd0);
      runToDone(50);
      checkOutput("bad_recover_writes", 32'(nwr), 32'd1);

      // Start while busy is ignored
      gnt_pct = 50;
      applyStimulus(32'h4000, 32'd1, 32'd16);
      stepCycle();
      lhs_rows = 32'd5; dst_base_addr = 32'h9000; start = 1'b1;
      stepCycle();
      start = 1'b0;
      runToDone(200);
      checkOutput("busy_start_writes", 32'(nwr), 32'd4);
      checkOutput("busy_start_done_count", 32'(ndone), 32'd1);
      gnt_pct = 100;

      // Reset after two writes, then a fresh job from 0x2000
      applyStimulus(32'h1000, 32'd2, 32'd8);
      for (int n = 0; n < 40 && nwr < 2; n++) stepCycle();
      checkOutput("rst_mid_writes", 32'(nwr), 32'd2);
      rst = 1'b1;
      stepCycle();
      checkResetOutputs("rst_mid");
      rst = 1'b0;
      applyStimulus(32'h2000, 32'd1, 32'd16);
      runToDone(50);
      checkOutput("rst_new_writes", 32'(nwr), 32'd4);

      // Address wrap at the top of the address space
      applyStimulus(32'hFFFF_FFF8, 32'd1, 32'd16);
      runToDone(50);
      checkOutput("wrap_writes", 32'(nwr), 32'd4);

      // Random jobs with random handshake pressure
      seq_mode = 1'b0;
      for (int j = 0; j < 8; j++) begin
         rdy_pct = $urandom_range(100, 20);
         gnt_pct = $urandom_range(100, 20);
         applyStimulus($urandom & 32'hFFFF_FFFC, 32'($urandom_range(3, 1)),
                       32'(4 * $urandom_range(4, 1)));
         runToDone(600);
         checkOutput("rand_writes", 32'(nwr), exp_total);
         checkOutput("rand_done_count", 32'(ndone), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pa_dst_writeback.md
Name: pa_dst_writeback

Overview:
- Output write-back stage directly downstream of the PE-array top.
- Consumes packed 4×int8 requantized results over the write_rdy/write_acq handshake and buffers them in a small FIFO.
- Issues word writes of those results to the destination memory at generated addresses.
- Tracks the total output count for one matrix-multiply job and signals completion or a configuration error.

Parameters:
- DATA_W, 32, width of one packed result word (4 × 8-bit results).
- ADDR_W, 32, width of memory byte address.
- FIFO_DEPTH, 4, entries in the result FIFO; power of two, ≥2.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle pulse; latches config and starts a job when idle.
- dst_base_addr  input  ADDR_W  byte address of the first output word; must be 4-byte aligned.
- lhs_rows  input  32  number of output rows; bits [15:0] are used.
- rhs_rows  input  32  output channels per row; bits [17:0] are used; must be a multiple of 4.
- result_in  input  DATA_W  packed results from the upstream stage, byte0 = lane 0.
- write_rdy  input  1  upstream has a valid result_in.
- write_acq  output  1  block accepts result_in this cycle.
- mem_wr_req  output  1  memory write request.
- mem_wr_addr  output  ADDR_W  byte address of the current write.
- mem_wr_data  output  DATA_W  data of the current write.
- mem_wr_gnt  input  1  memory accepts the write this cycle.
- busy  output  1  job in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  sticky configuration error, cleared by the next accepted start or by rst.

Behaviour:
- Reset: rst=1 at a clock edge clears all of the following; effective mid-job, discarding FIFO contents and any in-flight request.
  - Outputs: write_acq=0, mem_wr_req=0, mem_wr_addr=0, mem_wr_data=0, busy=0, done=0, err=0.
  - Internal: FIFO empty, counters 0, state=IDLE.
- Config latch on start in IDLE:
  - Latch base address.
  - total_words = lhs_rows[15:0] × rhs_rows[17:2], 32-bit, unsigned.
  - Clear err, in_cnt, out_cnt.
- State machine, states IDLE, RUN, FIN:
  - IDLE + start + rhs_rows[1:0]≠0 → stay IDLE, err=1 next cycle, no done.
  - IDLE + start + total_words==0 → FIN, no memory traffic.
  - IDLE + start otherwise → RUN, busy=1 next cycle.
  - RUN → FIN when out_cnt==total_words, i.e. after the last grant.
  - FIN: done=1 for exactly one cycle, busy=0, then → IDLE.
  - start outside IDLE is ignored.
- Input handshake:
  - write_acq=1 iff state==RUN && in_cnt<total_words && FIFO count<FIFO_DEPTH, decoded from registered state only.
  - A transfer occurs when write_rdy && write_acq; the word is pushed and in_cnt increments.
  - When the FIFO is full, write_acq=0 even if a pop occurs in the same cycle.
  - Upstream holds result_in stable while write_rdy=1 and no transfer has occurred.
- Output handshake:
  - mem_wr_req=1 whenever the FIFO is non-empty in RUN.
  - mem_wr_data = FIFO head; mem_wr_addr = base + 4×out_cnt, modulo 2^ADDR_W.
  - Both are held stable until mem_wr_req && mem_wr_gnt; on that cycle pop and increment out_cnt.
  - mem_wr_gnt while mem_wr_req=0 is ignored.
- Latency and throughput:
  - A word accepted in cycle N is presented on mem_wr_req at the earliest in cycle N+1.
  - With mem_wr_gnt held high, sustained throughput is 1 word/cycle; the FIFO never fills.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, order preserved.
- Ordering: words are written strictly in acceptance order to consecutive addresses.

Test Plan:
- Normal job: base=0x1000, lhs_rows=2, rhs_rows=8, mem_wr_gnt=1, write_rdy=1 with results 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D → 4 writes to 0x1000, 0x1004, 0x1008, 0x100C with matching data; done pulses once; busy returns to 0; write_acq=0 after the 4th accept.
- Backpressure: same job with mem_wr_gnt=0 → write_acq drops after exactly FIFO_DEPTH=4 accepts and mem_wr_req/addr/data hold at 0x1000/0x04030201. Then raise gnt → all 4 writes complete in order, then done.
- Zero rows: lhs_rows=0, rhs_rows=16, start → no mem_wr_req; done pulse 2 cycles after start; err=0.
- Bad config: rhs_rows=6, start → err=1, busy=0, write_acq stays 0, no done. A following valid start clears err.
- Start while busy during a 4-word job → ignored; exactly 4 writes and one done.
- Reset mid-job: rst=1 after 2 of 4 writes → next cycle all outputs 0 and FIFO empty. A new start with base=0x2000 writes from 0x2000.
